compuerta: RTL and testbench
============================

# compuerta

Branch/jump resolution gate for the Execute stage of the pipelined vector-encryption CPU. It combines the ALU `zeroE` and `negative` flags with the decoded `jumpE` and `branchE` controls. It produces `pcSrcE`, the combinational PC-source select that redirects fetch. A small clocked monitor section registers the decision and keeps wrap-around event counters for debug and performance readout.

## Interface
Parameters:
- `CNT_W`, default 32: width of each event counter.

Ports:
- `clk` input 1: single system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `zeroE` input 1: ALU result equals zero (Execute stage).
- `jumpE` input 1: unconditional jump decoded in Execute.
- `branchE` input 1: conditional branch decoded in Execute.
- `negative` input 1: ALU result sign flag (compare result is less-than).
- `pcSrcE` output 1: PC source select; 1 selects the branch/jump target. Combinational.
- `pcSrcE_q` output 1: `pcSrcE` registered one cycle.
- `jump_cnt` output CNT_W: cycles with `jumpE`=1.
- `br_taken_cnt` output CNT_W: cycles with a taken conditional branch.
- `br_ntaken_cnt` output CNT_W: cycles with `branchE`=1 and the branch not taken.

## Operation
- Branch condition: `br_take = branchE & negative & ~zeroE`. The branch is taken only on a strictly-negative, non-zero result (signed less-than).
- `pcSrcE = jumpE | br_take`. This is pure combinational logic with no dependence on `clk` or `rst_n`, so it is valid even when `clk` and `rst_n` are unconnected.
- Jump has priority over branch. If `jumpE`=1, `pcSrcE`=1 regardless of the flags.
- Event counting on each rising `clk` while `rst_n`=1:
  - `jump_cnt` += 1 when `jumpE`=1.
  - `br_taken_cnt` += 1 when `br_take`=1 and `jumpE`=0.
  - `br_ntaken_cnt` += 1 when `branchE`=1, `br_take`=0 and `jumpE`=0.
  - With `jumpE` and `branchE` both 1, only `jump_cnt` increments.
- Counters wrap modulo 2^CNT_W. There is no saturation and no overflow flag.
- `pcSrcE_q` takes `pcSrcE` on each rising edge.

## Timing
- `pcSrcE` has zero-cycle latency: it settles within the same cycle the inputs change.
- `pcSrcE_q` and the counters have a latency of 1 cycle and reflect the inputs sampled at the previous rising edge.
- Reset:
  - When `rst_n` falls, `pcSrcE_q`=0 and all counters are 0 immediately, with no clock edge required.
  - They stay at 0 while `rst_n`=0. `pcSrcE` still follows its inputs during reset.
- Reset release: counting resumes at the first rising edge after `rst_n` returns to 1.
- Reset asserted mid-count clears all state, and the pre-reset values are lost.
- Counter wrap: a counter at all-ones with an event goes to 0 on the next edge.

## Test plan
- All inputs 0 -> `pcSrcE`=0. Inputs `zeroE`=1, `branchE`=1, `negative`=0, `jumpE`=0 -> `pcSrcE`=0 after 10 ns.
- `zeroE`=0, `jumpE`=1, `branchE`=1, `negative`=1 -> `pcSrcE`=1. Also `zeroE`=1 with the same other inputs -> `pcSrcE`=1 (jump priority).
- `branchE`=1, `negative`=1, `zeroE`=0, `jumpE`=0 -> `pcSrcE`=1. Changing to `zeroE`=1 -> `pcSrcE`=0. Changing to `negative`=0, `zeroE`=0 -> `pcSrcE`=0.
- With `clk` running after reset, apply 3 jump cycles, 2 taken-branch cycles, 4 not-taken-branch cycles, and 1 cycle with jump and branch both 1. Required counts: `jump_cnt`=4, `br_taken_cnt`=2, `br_ntaken_cnt`=4. `pcSrcE_q` must lag `pcSrcE` by exactly one cycle.
- Assert `rst_n`=0 between clock edges with nonzero counters -> all counters and `pcSrcE_q` go to 0 immediately, and stay 0 until the first edge after release.
- With `CNT_W`=4, apply 16 jump cycles -> `jump_cnt` wraps from 15 to 0.

Source files
------------

// File: rtl/compuerta_if.sv
// compuerta_if -- Execute-stage resolution bundle.
//   zeroE, negative : ALU flags for the instruction in Execute
//   jumpE, branchE  : decoded control for the same instruction
//   pcSrcE          : resolved PC-source select back to fetch
// master: the side that owns the Execute flags and consumes pcSrcE.
// slave : the resolution gate itself.
interface compuerta_if;
    logic zeroE;
    logic jumpE;
    logic branchE;
    logic negative;
    logic pcSrcE;

    modport master (
        output zeroE, jumpE, branchE, negative,
        input  pcSrcE
    );

    modport slave (
        input  zeroE, jumpE, branchE, negative,
        output pcSrcE
    );
endinterface

// File: rtl/compuerta.sv
// compuerta -- branch/jump resolution gate for the Execute stage.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset (monitor only)
//   ex             : Execute flags in, pcSrcE out (purely combinational)
//   pcSrcE_q       : pcSrcE registered one cycle
//   jump_cnt       : cycles with jumpE set
//   br_taken_cnt   : cycles with a taken conditional branch (no jump)
//   br_ntaken_cnt  : cycles with a not-taken conditional branch (no jump)
// Counters are CNT_W wide and wrap silently.
module compuerta #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    compuerta_if.slave       ex,
    output logic             pcSrcE_q,
    output logic [CNT_W-1:0] jump_cnt,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] br_ntaken_cnt
);
    localparam int NUM_EVT = 3;

    logic               brTake;
    logic [NUM_EVT-1:0] evt;
    logic [NUM_EVT-1:0][CNT_W-1:0] evtCnt;

    // Signed less-than: negative and not zero. The select path touches no
    // state, so fetch redirect is valid even with the clock stopped.
    assign brTake    = ex.branchE & ex.negative & ~ex.zeroE;
    assign ex.pcSrcE = ex.jumpE | brTake;

    // Events are mutually exclusive; a jump masks any branch in the same
    // cycle so each cycle lands in at most one bucket.
    assign evt[0] = ex.jumpE;
    assign evt[1] = ~ex.jumpE & brTake;
    assign evt[2] = ~ex.jumpE & ex.branchE & ~brTake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcSrcE_q <= 1'b0;
        else        pcSrcE_q <= ex.pcSrcE;
    end

    for (genvar g = 0; g < NUM_EVT; g++) begin : gEvtCnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      evtCnt[g] <= '0;
            else if (evt[g]) evtCnt[g] <= evtCnt[g] + CNT_W'(1);
        end
    end

    assign jump_cnt      = evtCnt[0];
    assign br_taken_cnt  = evtCnt[1];
    assign br_ntaken_cnt = evtCnt[2];
endmodule

// File: tb/tb_compuerta.sv
module tb_compuerta;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    compuerta_if exIf();
    compuerta_if exIf4();

    logic        pcSrcE_q, pcSrcE_q4;
    logic [31:0] jumpCnt, brTakenCnt, brNtakenCnt;
    logic [3:0]  jumpCnt4, brTakenCnt4, brNtakenCnt4;

    compuerta #(.CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .ex(exIf),
        .pcSrcE_q(pcSrcE_q), .jump_cnt(jumpCnt),
        .br_taken_cnt(brTakenCnt), .br_ntaken_cnt(brNtakenCnt)
    );

    compuerta #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ex(exIf4),
        .pcSrcE_q(pcSrcE_q4), .jump_cnt(jumpCnt4),
        .br_taken_cnt(brTakenCnt4), .br_ntaken_cnt(brNtakenCnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        q;
        logic [31:0] j;
        logic [31:0] t;
        logic [31:0] n;
        logic [3:0]  j4;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   failures = 0;

    // model state: inputs currently applied and registered values
    logic        curRst = 1'b0, curJ = 1'b0, curP = 1'b0, curJ4 = 1'b0;
    logic        curTake = 1'b0, curB = 1'b0;
    logic        mQ = 1'b0;
    logic [31:0] mJ = 0, mT = 0, mN = 0;
    logic [3:0]  mJ4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle, applied 1 ns after a rising edge. take is the
    // hand-derived taken-branch condition, p the hand-derived pcSrcE.
    task automatic step(input logic rst, input logic z, input logic j, input logic b,
                        input logic n, input logic take, input logic p, input logic j4);
        exp_t e;
        @(posedge clk);
        #1;
        if (curRst) begin
            mQ = curP;
            if (curJ)         mJ = mJ + 1;
            else if (curTake) mT = mT + 1;
            else if (curB)    mN = mN + 1;
            if (curJ4)        mJ4 = mJ4 + 4'd1;
        end
        rst_n = rst;
        exIf.zeroE = z; exIf.jumpE = j; exIf.branchE = b; exIf.negative = n;
        exIf4.jumpE = j4;
        curRst = rst; curJ = j; curB = b; curTake = take; curP = p; curJ4 = j4;
        if (!rst) begin
            mQ = 0; mJ = 0; mT = 0; mN = 0; mJ4 = 0;
        end
        e.p = p; e.q = mQ; e.j = mJ; e.t = mT; e.n = mN; e.j4 = mJ4;
        sbQ.push_back(e);
    endtask

    // monitor: every falling edge presents one sample to score
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                chk("pcSrcE", 32'(exIf.pcSrcE), 32'(e.p));
                chk("pcSrcE_q", 32'(pcSrcE_q), 32'(e.q));
                chk("jump_cnt", jumpCnt, e.j);
                chk("br_taken_cnt", brTakenCnt, e.t);
                chk("br_ntaken_cnt", brNtakenCnt, e.n);
                chk("jump_cnt4", 32'(jumpCnt4), 32'(e.j4));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        exIf.zeroE = 0; exIf.jumpE = 0; exIf.branchE = 0; exIf.negative = 0;
        exIf4.zeroE = 0; exIf4.jumpE = 0; exIf4.branchE = 0; exIf4.negative = 0;

        // reset state + combinational decode while in reset
        //    rst z j b n take p j4
        step(0, 0,0,0,0, 0, 0, 0);
        step(0, 1,0,1,0, 0, 0, 0);
        step(0, 0,1,1,1, 1, 1, 0);
        step(0, 1,1,1,1, 0, 1, 0);
        step(0, 0,0,1,1, 1, 1, 0);
        step(0, 1,0,1,1, 0, 0, 0);
        step(0, 0,0,1,0, 0, 0, 0);

        // release, then count: 3 jumps, 2 taken, 4 not taken, 1 jump+branch
        step(1, 0,0,0,0, 0, 0, 0);
        step(1, 0,1,0,0, 0, 1, 0);
        step(1, 1,1,0,1, 0, 1, 0);
        step(1, 0,1,0,0, 0, 1, 0);
        step(1, 0,0,1,1, 1, 1, 0);
        step(1, 0,0,1,1, 1, 1, 0);
        step(1, 0,0,1,0, 0, 0, 0);
        step(1, 1,0,1,1, 0, 0, 0);
        step(1, 1,0,1,0, 0, 0, 0);
        step(1, 0,0,1,0, 0, 0, 0);
        step(1, 0,1,1,1, 1, 1, 0);
        step(1, 0,0,0,0, 0, 0, 0);
        @(negedge clk);
        chk("total_jump", jumpCnt, 32'd4);
        chk("total_taken", brTakenCnt, 32'd2);
        chk("total_ntaken", brNtakenCnt, 32'd4);

        // asynchronous reset between edges with nonzero counters
        step(0, 0,1,0,0, 0, 1, 0);
        step(0, 0,0,0,0, 0, 0, 0);
        step(1, 0,1,0,0, 0, 1, 0);
        step(1, 0,0,0,0, 0, 0, 0);

        // 4-bit counter wraps after 16 jumps
        for (int i = 0; i < 16; i++) step(1, 0,0,0,0, 0, 0, 1);
        step(1, 0,0,0,0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_jump4", 32'(jumpCnt4), 32'd0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
